// File: rtl/debug_dma_reader.sv
// debug_dma_reader: reads a block of cart memory word-by-word over the device bus
// and streams it toward the USB transmit path as big-endian bytes (MSB first).
module debug_dma_reader #(
  parameter int ADDR_W = 26,
  parameter int LEN_W  = 20
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [3:0]        i_bank,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LEN_W-1:0]  i_length,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_request,
  output logic              o_write,
  input  logic              i_busy,
  input  logic              i_ack,
  output logic [3:0]        o_bank,
  output logic [ADDR_W-1:0] o_address,
  input  logic [31:0]       i_data,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT_ACK,
    S_SEND
  } state_t;

  state_t            r_state;
  logic [3:0]        r_bank;
  logic [ADDR_W-1:0] r_address;
  logic [LEN_W-1:0]  r_remaining;
  logic [31:0]       r_shift;
  logic [2:0]        r_word_bytes;
  logic              r_abort_pending;
  logic              r_busy;
  logic              r_done;
  logic              r_request;
  logic              r_tx_valid;

  logic              w_accept;
  logic              w_handshake;
  logic [2:0]        w_first_word_bytes;

  assign w_accept           = r_request && !i_busy;
  assign w_handshake        = r_tx_valid && i_tx_ready;
  assign w_first_word_bytes = (r_remaining > LEN_W'(4)) ? 3'd4 : r_remaining[2:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_bank          <= '0;
      r_address       <= '0;
      r_remaining     <= '0;
      r_shift         <= '0;
      r_word_bytes    <= '0;
      r_abort_pending <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_request       <= 1'b0;
      r_tx_valid      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            if (i_length != '0) begin
              r_bank          <= i_bank;
              r_address       <= i_address & ~ADDR_W'(3);
              r_remaining     <= i_length;
              r_abort_pending <= 1'b0;
              r_busy          <= 1'b1;
              r_request       <= 1'b1;
              r_state         <= S_REQUEST;
            end else begin
              r_done <= 1'b1;
            end
          end
        end

        // Acceptance beats a same-cycle abort: once the responder has the
        // request it will ack, so the abort is deferred until that ack.
        S_REQUEST: begin
          if (w_accept) begin
            r_request       <= 1'b0;
            r_abort_pending <= i_abort;
            r_state         <= S_WAIT_ACK;
          end else if (i_abort) begin
            r_request <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        S_WAIT_ACK: begin
          if (i_ack) begin
            if (r_abort_pending || i_abort) begin
              r_abort_pending <= 1'b0;
              r_busy          <= 1'b0;
              r_done          <= 1'b1;
              r_state         <= S_IDLE;
            end else begin
              r_shift      <= i_data;
              r_word_bytes <= w_first_word_bytes;
              r_tx_valid   <= 1'b1;
              r_state      <= S_SEND;
            end
          end else if (i_abort) begin
            r_abort_pending <= 1'b1;
          end
        end

        S_SEND: begin
          if (i_abort) begin
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_IDLE;
          end else if (w_handshake) begin
            r_shift      <= {r_shift[23:0], 8'h00};
            r_word_bytes <= r_word_bytes - 3'd1;
            r_remaining  <= r_remaining - LEN_W'(1);
            if (r_word_bytes == 3'd1) begin
              r_tx_valid <= 1'b0;
              if (r_remaining == LEN_W'(1)) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_address <= r_address + ADDR_W'(4);
                r_request <= 1'b1;
                r_state   <= S_REQUEST;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_request  = r_request;
  assign o_write    = 1'b0;
  assign o_bank     = r_bank;
  assign o_address  = r_address;
  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = r_shift[31:24];

endmodule

// File: tb/tb_debug_dma_reader.sv
// Bench for debug_dma_reader: bus responder and byte sink run on the falling
// edge; expected addresses, read data and bytes are queued when stimulus is set up.
module tb_debug_dma_reader;
  localparam int ADDR_W = 26;
  localparam int LEN_W  = 20;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_start, i_abort;
  logic [3:0]        i_bank;
  logic [ADDR_W-1:0] i_address;
  logic [LEN_W-1:0]  i_length;
  logic              o_busy, o_done, o_request, o_write;
  logic              i_busy, i_ack;
  logic [3:0]        o_bank;
  logic [ADDR_W-1:0] o_address;
  logic [31:0]       i_data;
  logic              o_tx_valid;
  logic [7:0]        o_tx_data;
  logic              i_tx_ready;

  debug_dma_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_bank(i_bank), .i_address(i_address), .i_length(i_length),
    .o_busy(o_busy), .o_done(o_done), .o_request(o_request), .o_write(o_write),
    .i_busy(i_busy), .i_ack(i_ack), .o_bank(o_bank), .o_address(o_address),
    .i_data(i_data), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
    .i_tx_ready(i_tx_ready)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, done_cnt = 0, done_cycle = -1, ack_cycle = -2;
  int req_cnt = 0, byte_cnt = 0;
  int busy_cfg = 0, lat_cfg = 2, ready_mode = 0;
  logic [31:0]       resp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [7:0]        exp_byte_q[$];

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // Bus responder: decides busy/ack for the coming rising edge.
  initial begin : responder
    int busy_left, cnt;
    bit req_seen, pending;
    logic [ADDR_W-1:0] held_addr, ea;
    logic [3:0] held_bank;
    i_busy = 0; i_ack = 0; i_data = '0;
    busy_left = 0; cnt = 0; req_seen = 0; pending = 0; held_addr = '0; held_bank = '0;
    forever begin
      @(negedge i_clk);
      i_ack = 1'b0;
      n_checks++;
      if (o_write !== 1'b0) begin
        n_errors++;
        $display("FAIL o_write: got %b, required 0", o_write);
      end
      if (i_reset) begin
        req_seen = 0; pending = 0; busy_left = 0; i_busy = 0;
      end else begin
        if (pending) begin
          if (cnt <= 1) begin
            i_ack = 1'b1;
            i_data = (resp_q.size() != 0) ? resp_q.pop_front() : 32'hBAD0_BAD0;
            ack_cycle = cyc + 1;
            pending = 0;
          end else begin
            cnt--;
          end
        end
        if (o_request) begin
          if (!req_seen) begin
            req_seen = 1; held_addr = o_address; held_bank = o_bank; busy_left = busy_cfg;
            req_cnt++;
            n_checks++;
            if (pending) begin
              n_errors++;
              $display("FAIL outstanding: got a second request at %h, required at most one", o_address);
            end
          end else begin
            n_checks++;
            if (o_address !== held_addr || o_bank !== held_bank) begin
              n_errors++;
              $display("FAIL addr_stable: got %h/%h, required %h/%h", o_bank, o_address, held_bank, held_addr);
            end
          end
          if (busy_left > 0) begin
            i_busy = 1'b1;
            busy_left--;
          end else begin
            i_busy = 1'b0;
            n_checks++;
            if (exp_addr_q.size() == 0) begin
              n_errors++;
              $display("FAIL req_addr: got request at %h, required none", o_address);
            end else begin
              ea = exp_addr_q.pop_front();
              if (o_address !== ea) begin
                n_errors++;
                $display("FAIL req_addr: got %h, required %h", o_address, ea);
              end else begin
                $display("request bank %0d addr %h accepted", o_bank, o_address);
              end
            end
            req_seen = 0; pending = 1; cnt = lat_cfg;
          end
        end else begin
          req_seen = 0;
          i_busy = 1'b0;
        end
      end
    end
  end

  // Byte sink: applies the ready pattern and scores accepted bytes.
  initial begin : sink
    logic [7:0] eb;
    i_tx_ready = 1'b1;
    forever begin
      @(negedge i_clk);
      case (ready_mode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = ~i_tx_ready;
        default: i_tx_ready = 1'b0;
      endcase
      if (o_done) begin
        done_cnt++;
        done_cycle = cyc;
      end
      if (!i_reset && o_tx_valid && i_tx_ready) begin
        byte_cnt++;
        n_checks++;
        if (exp_byte_q.size() == 0) begin
          n_errors++;
          $display("FAIL tx_byte: got unexpected byte %h, required none", o_tx_data);
        end else begin
          eb = exp_byte_q.pop_front();
          if (o_tx_data !== eb) begin
            n_errors++;
            $display("FAIL tx_byte: got %h, required %h", o_tx_data, eb);
          end else begin
            $display("byte %h accepted", o_tx_data);
          end
        end
      end
    end
  end

  task automatic push_word(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input int nbytes);
    logic [31:0] d;
    d = data;
    exp_addr_q.push_back(addr);
    resp_q.push_back(data);
    for (int k = 0; k < nbytes; k++) exp_byte_q.push_back(d[31-8*k -: 8]);
  endtask

  task automatic start_xfer(input logic [3:0] bank, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    @(negedge i_clk);
    i_bank = bank; i_address = addr; i_length = len; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge i_clk);
      if (done_cnt > base) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic finish_xfer(input string name, input int done_base, input int req_base, input int req_exp);
    bit ok;
    wait_done(done_base, ok);
    repeat (3) @(negedge i_clk);
    n_checks++;
    if (!ok || done_cnt != done_base + 1) begin
      n_errors++;
      $display("FAIL %s_done: got %0d done pulses, required 1", name, done_cnt - done_base);
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_idle: got o_busy %b, required 0", name, o_busy);
    end
    n_checks++;
    if (exp_byte_q.size() != 0 || exp_addr_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: got %0d bytes %0d requests missing, required 0", name, exp_byte_q.size(), exp_addr_q.size());
    end
    n_checks++;
    if (req_cnt - req_base != req_exp) begin
      n_errors++;
      $display("FAIL %s_requests: got %0d, required %0d", name, req_cnt - req_base, req_exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_request !== 1'b0 || o_tx_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got busy %b req %b valid %b, required 0 0 0", o_busy, o_request, o_tx_valid);
    end
    n_checks++;
    if ({o_done, o_write, o_bank, o_address, o_tx_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got done %b bank %h addr %h data %h, required all 0", o_done, o_bank, o_address, o_tx_data);
    end
    i_reset = 1'b0;
  endtask

  task automatic test_basic();
    int db, rb;
    db = done_cnt; rb = req_cnt; lat_cfg = 2;
    push_word(26'h0000100, 32'h11223344, 4);
    push_word(26'h0000104, 32'h55667788, 4);
    start_xfer(4'd1, 26'h0000100, 20'd8);
    n_checks++;
    if (o_busy !== 1'b1 || o_request !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_cycle1: got busy %b req %b, required 1 1", o_busy, o_request);
    end
    n_checks++;
    if (o_bank !== 4'd1 || o_address !== 26'h0000100) begin
      n_errors++;
      $display("FAIL basic_bus: got bank %h addr %h, required 1 0000100", o_bank, o_address);
    end
    finish_xfer("basic", db, rb, 2);
  endtask

  task automatic test_partial();
    int db, rb;
    db = done_cnt; rb = req_cnt;
    push_word(26'h0000200, 32'hAABBCCDD, 4);
    push_word(26'h0000204, 32'hEEFF0011, 2);
    start_xfer(4'd2, 26'h0000202, 20'd6);
    finish_xfer("partial", db, rb, 2);
  endtask

  task automatic test_backpressure();
    int db, rb;
    db = done_cnt; rb = req_cnt; busy_cfg = 5; ready_mode = 1;
    push_word(26'h0000300, 32'h01020304, 4);
    push_word(26'h0000304, 32'hA5B6C7D8, 4);
    push_word(26'h0000308, 32'hF0E1D2C3, 3);
    start_xfer(4'd3, 26'h0000300, 20'd11);
    finish_xfer("backpressure", db, rb, 3);
    busy_cfg = 0; ready_mode = 0;
  endtask

  task automatic test_wrap();
    int db, rb;
    db = done_cnt; rb = req_cnt;
    push_word(26'h3FFFFFC, 32'hCAFEF00D, 4);
    push_word(26'h0000000, 32'h8BADF00D, 4);
    start_xfer(4'd4, 26'h3FFFFFC, 20'd8);
    finish_xfer("wrap", db, rb, 2);
  endtask

  task automatic test_zero_length();
    int db, rb;
    db = done_cnt; rb = req_cnt;
    start_xfer(4'd5, 26'h0000400, 20'd0);
    n_checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_done: got done %b busy %b at cycle 1, required 1 0", o_done, o_busy);
    end
    repeat (5) @(negedge i_clk);
    n_checks++;
    if (req_cnt != rb) begin
      n_errors++;
      $display("FAIL zero_request: got %0d requests, required 0", req_cnt - rb);
    end
  endtask

  task automatic test_abort_wait_ack();
    int db, rb, bb;
    bit ok;
    db = done_cnt; rb = req_cnt; bb = byte_cnt; lat_cfg = 5;
    exp_addr_q.push_back(26'h0000500);
    resp_q.push_back(32'hDEADBEEF);
    start_xfer(4'd6, 26'h0000500, 20'd8);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (o_busy && !o_request) begin
        ok = 1;
        break;
      end
      @(negedge i_clk);
    end
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL abort_accept: got no request acceptance, required one");
    end
    finish_xfer("abort", db, rb, 1);
    n_checks++;
    if (done_cycle != ack_cycle) begin
      n_errors++;
      $display("FAIL abort_timing: got done at cycle %0d, required %0d (ack cycle)", done_cycle, ack_cycle);
    end
    n_checks++;
    if (byte_cnt != bb) begin
      n_errors++;
      $display("FAIL abort_bytes: got %0d bytes, required 0", byte_cnt - bb);
    end
    lat_cfg = 1;
    db = done_cnt; rb = req_cnt;
    push_word(26'h0000600, 32'h13579BDF, 4);
    start_xfer(4'd7, 26'h0000600, 20'd4);
    finish_xfer("after_abort", db, rb, 1);
    lat_cfg = 2;
  endtask

  task automatic test_reset_mid_send();
    int db, rb;
    bit ok;
    ready_mode = 2;
    push_word(26'h0000700, 32'h77665544, 0);
    start_xfer(4'd8, 26'h0000700, 20'd8);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge i_clk);
      if (o_tx_valid) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL midsend_reach: got no o_tx_valid, required SEND");
    end
    #2 i_reset = 1'b1;
    #1;
    n_checks++;
    if ({o_busy, o_done, o_request, o_write, o_bank, o_address, o_tx_valid, o_tx_data} !== '0) begin
      n_errors++;
      $display("FAIL midsend_reset: got busy %b req %b valid %b bank %h addr %h data %h, required all 0",
               o_busy, o_request, o_tx_valid, o_bank, o_address, o_tx_data);
    end
    repeat (2) @(negedge i_clk);
    resp_q.delete(); exp_addr_q.delete(); exp_byte_q.delete();
    i_reset = 1'b0;
    ready_mode = 0;
    db = done_cnt; rb = req_cnt;
    push_word(26'h0000800, 32'h2468ACE0, 4);
    push_word(26'h0000804, 32'h0F1E2D3C, 1);
    start_xfer(4'd9, 26'h0000800, 20'd5);
    finish_xfer("post_reset", db, rb, 2);
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_bank = '0; i_address = '0; i_length = '0;
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_wrap();
    test_zero_length();
    test_abort_wait_ack();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
